bist_data_comparator: RTL and testbench
=======================================

Name: bist_data_comparator

Overview:
- Registered memory-BIST result comparator. Each enabled cycle it compares the expected pattern (data_t) against the RAM read data (ramout).
- Produces one-hot greater/equal/less flags, a sticky fail flag, a saturating mismatch counter and a first-failure capture.
- Sits between the BIST pattern generator / RAM read port and the BIST controller's pass/fail logic.

Parameters:
- WIDTH, 8, bit width of data_t and ramout.
- CNT_W, 16, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- cmp_en  input  1  compare strobe; data_t/ramout sampled when high.
- clr  input  1  synchronous clear of fail, err_cnt and capture registers.
- data_t  input  WIDTH  expected data from the pattern generator.
- ramout  input  WIDTH  data read from the RAM under test.
- cmp_valid  output  1  high for one cycle after each enabled compare.
- gt  output  1  data_t > ramout (unsigned), registered.
- eq  output  1  data_t == ramout, registered.
- lt  output  1  data_t < ramout (unsigned), registered.
- fail  output  1  sticky: at least one mismatch since reset/clr.
- err_cnt  output  CNT_W  number of mismatching compares, saturating.
- first_exp  output  WIDTH  data_t of the first mismatch.
- first_act  output  WIDTH  ramout of the first mismatch.
- diff_bits  output  WIDTH  data_t XOR ramout of the last compare, registered.

Behaviour:
- Reset (async, rst=1): gt=lt=eq=0, cmp_valid=0, fail=0, err_cnt=0, first_exp=first_act=diff_bits=0.
- Latency is 1 cycle. Inputs are sampled on the rising clk edge when cmp_en=1, and results are visible after that edge.
- Comparison is unsigned over all WIDTH bits.
- After any enabled compare, exactly one of gt/eq/lt is 1.
- cmp_en=0: gt/eq/lt/diff_bits hold their last value; cmp_valid=0 next cycle.
- Mismatch means eq result is 0. On a mismatch:
  - fail is set and stays set.
  - err_cnt increments by 1 and saturates at all-ones (no wrap).
  - If fail was 0 before this compare, first_exp/first_act capture data_t/ramout. Later mismatches do not overwrite them.
- clr=1: next edge sets fail=0, err_cnt=0, first_exp=first_act=0.
- clr and cmp_en both high in the same cycle:
  - gt/eq/lt/diff_bits/cmp_valid update normally.
  - clr has priority on fail/err_cnt/capture, so that cycle's mismatch is discarded.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- No internal state machine; purely datapath plus sticky/counter registers.

Optional Feature:
- Macro: BIST_CMP_MASK_EN.
- When defined:
  - Adds input port cmp_mask [WIDTH] (1 = bit is compared, 0 = ignored).
  - Masked-off bits are forced to 0 in both operands before gt/eq/lt evaluation, diff_bits, and the mismatch decision.
  - Capture registers still store the raw unmasked data.
- When undefined: no cmp_mask port; all bits are compared, equivalent to mask all-ones.

Test Plan:
- Reset then data_t=0x00, ramout=0x00, cmp_en=1 -> next cycle eq=1, gt=lt=0, cmp_valid=1, fail=0, err_cnt=0.
- data_t=0x10/ramout=0x00, then 0x20/0x10 -> gt=1 each cycle; fail=1; err_cnt=2; first_exp=0x10, first_act=0x00; diff_bits=0x30 after the second compare.
- data_t=0x20, ramout=0x30 -> lt=1, diff_bits=0x10. Then 0x50/0x50, 0xA0/0xA0, 0xF0/0xF0 -> eq=1 each cycle; fail stays 1; err_cnt unchanged.
- Force err_cnt near max (CNT_W=2 build), apply 5 mismatches -> err_cnt=3, no wrap. Pulse clr with a mismatching cmp_en -> fail=0, err_cnt=0, lt/gt still updated.
- Assert rst asynchronously mid-stream between edges -> all outputs 0 immediately. cmp_en=0 for several cycles -> flags hold, cmp_valid=0.
- With BIST_CMP_MASK_EN: cmp_mask=0xF0, data_t=0xA5, ramout=0xA3 -> eq=1, no fail. cmp_mask=0xFF on the same data -> gt=1, fail=1.

Source files
------------

// File: rtl/bist_data_comparator.sv
// Memory-BIST result comparator: gt/eq/lt flags, sticky fail, saturating error count, first-failure capture.
// Latency: 1 cycle from cmp_en sample to registered results and cmp_valid.
// Backpressure: none; a compare is accepted on every cycle that cmp_en is high.
// Optional feature: define BIST_CMP_MASK_EN to add a per-bit cmp_mask input.
module bist_data_comparator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmp_en,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_t,
   input  logic [WIDTH-1:0] ramout,
`ifdef BIST_CMP_MASK_EN
   input  logic [WIDTH-1:0] cmp_mask,
`endif
   output logic             cmp_valid,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             fail,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_act,
   output logic [WIDTH-1:0] diff_bits
);

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] exp_m;
   logic [WIDTH-1:0] act_m;
   logic             mismatch;

`ifdef BIST_CMP_MASK_EN
   assign mask = cmp_mask;
`else
   assign mask = {WIDTH{1'b1}};
`endif

   // Masked-off bits are zeroed in both operands so they cannot influence any result.
   assign exp_m    = data_t & mask;
   assign act_m    = ramout & mask;
   assign mismatch = (exp_m != act_m);

   // Per-compare result flags; they hold their value while cmp_en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_valid <= 1'b0;
         gt        <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         diff_bits <= '0;
      end else begin
         cmp_valid <= cmp_en;
         if (cmp_en) begin
            gt        <= (exp_m > act_m);
            eq        <= (exp_m == act_m);
            lt        <= (exp_m < act_m);
            diff_bits <= exp_m ^ act_m;
         end
      end
   end

   // Sticky fail, saturating counter and first-failure capture; clr wins over a same-cycle mismatch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail      <= 1'b0;
         err_cnt   <= '0;
         first_exp <= '0;
         first_act <= '0;
      end else if (clr) begin
         fail      <= 1'b0;
         err_cnt   <= '0;
         first_exp <= '0;
         first_act <= '0;
      end else if (cmp_en && mismatch) begin
         fail <= 1'b1;
         if (err_cnt != {CNT_W{1'b1}}) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
         // Capture keeps the raw operands so the failing address data can be inspected unmasked.
         if (!fail) begin
            first_exp <= data_t;
            first_act <= ramout;
         end
      end
   end

endmodule

// File: tb/tb_bist_data_comparator.sv
// Scoreboard bench for bist_data_comparator: expected responses queued at issue, checked by a monitor.
// A 2-bit error counter is used so saturation is reachable in a few compares.
// Direct checks cover reset state, clear-only cycles, hold behaviour and asynchronous reset.
module tb_bist_data_comparator;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   typedef struct packed {
      logic             gt;
      logic             eq;
      logic             lt;
      logic             fail;
      logic [CNT_W-1:0] cnt;
      logic [WIDTH-1:0] fe;
      logic [WIDTH-1:0] fa;
      logic [WIDTH-1:0] diff;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmp_en;
   logic             clr;
   logic [WIDTH-1:0] data_t;
   logic [WIDTH-1:0] ramout;
   logic [WIDTH-1:0] cmp_mask;
   logic             cmp_valid;
   logic             gt;
   logic             eq;
   logic             lt;
   logic             fail;
   logic [CNT_W-1:0] err_cnt;
   logic [WIDTH-1:0] first_exp;
   logic [WIDTH-1:0] first_act;
   logic [WIDTH-1:0] diff_bits;

   int n_total = 0;
   int n_pass  = 0;
   exp_t sb_q[$];

   bist_data_comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmp_en    (cmp_en),
      .clr       (clr),
      .data_t    (data_t),
      .ramout    (ramout),
`ifdef BIST_CMP_MASK_EN
      .cmp_mask  (cmp_mask),
`endif
      .cmp_valid (cmp_valid),
      .gt        (gt),
      .eq        (eq),
      .lt        (lt),
      .fail      (fail),
      .err_cnt   (err_cnt),
      .first_exp (first_exp),
      .first_act (first_act),
      .diff_bits (diff_bits)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: every cmp_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && cmp_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("gt",        {31'd0, gt},   {31'd0, e.gt});
            chk("eq",        {31'd0, eq},   {31'd0, e.eq});
            chk("lt",        {31'd0, lt},   {31'd0, e.lt});
            chk("fail",      {31'd0, fail}, {31'd0, e.fail});
            chk("err_cnt",   32'(err_cnt),   32'(e.cnt));
            chk("first_exp", 32'(first_exp), 32'(e.fe));
            chk("first_act", 32'(first_act), 32'(e.fa));
            chk("diff_bits", 32'(diff_bits), 32'(e.diff));
         end
      end
   end

   task automatic issue(input logic [7:0] d, input logic [7:0] r, input logic c,
                        input logic egt, input logic eeq, input logic elt, input logic efail,
                        input logic [CNT_W-1:0] ecnt, input logic [7:0] efe, input logic [7:0] efa,
                        input logic [7:0] ediff);
      exp_t e;
      @(negedge clk);
      data_t = d;
      ramout = r;
      clr    = c;
      cmp_en = 1'b1;
      e = '{gt: egt, eq: eeq, lt: elt, fail: efail, cnt: ecnt, fe: efe, fa: efa, diff: ediff};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cmp_en = 1'b0;
      clr    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, cmp_valid}, 32'd0);
      chk({tag, "_flags"}, {29'd0, gt, eq, lt}, 32'd0);
      chk({tag, "_fail"},  {31'd0, fail}, 32'd0);
      chk({tag, "_cnt"},   32'(err_cnt), 32'd0);
      chk({tag, "_fe"},    32'(first_exp), 32'd0);
      chk({tag, "_fa"},    32'(first_act), 32'd0);
      chk({tag, "_diff"},  32'(diff_bits), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      cmp_en   = 1'b0;
      clr      = 1'b0;
      data_t   = '0;
      ramout   = '0;
      cmp_mask = 8'hFF;
      do_reset();
      #1;
      chk_all_zero("reset");

      // Equal, then two greater-than mismatches, one less-than, three equals.
      issue(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      issue(8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h10, 8'h00, 8'h10);
      issue(8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h10, 8'h00, 8'h30);
      issue(8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h10, 8'h00, 8'h10);
      issue(8'h50, 8'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h10, 8'h00, 8'h00);
      issue(8'hA0, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h10, 8'h00, 8'h00);
      issue(8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h10, 8'h00, 8'h00);

      // Clear with no compare: sticky state drops, flags hold, no valid pulse.
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clr_fail",  {31'd0, fail}, 32'd0);
      chk("clr_cnt",   32'(err_cnt), 32'd0);
      chk("clr_fe",    32'(first_exp), 32'd0);
      chk("clr_fa",    32'(first_act), 32'd0);
      chk("clr_valid", {31'd0, cmp_valid}, 32'd0);
      chk("clr_hold",  {29'd0, gt, eq, lt}, 32'b010);

      // Five mismatches: counter saturates at 3, capture keeps the first one.
      for (int i = 0; i < 5; i++) begin
         logic [7:0] d;
         d = 8'h40 + 8'(i);
         issue(d, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, (i < 3) ? 2'(i + 1) : 2'd3,
               8'h40, 8'h01, d ^ 8'h01);
      end

      // clr together with a mismatching compare: flags update, mismatch discarded.
      issue(8'h02, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h83);
      // Capture re-arms after the clear.
      issue(8'h33, 8'h31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h33, 8'h31, 8'h02);

      // Idle cycles: results hold, no valid pulses.
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, cmp_valid}, 32'd0);
         chk("hold_flags", {29'd0, gt, eq, lt}, 32'b100);
         chk("hold_diff",  32'(diff_bits), 32'h02);
         chk("hold_cnt",   32'(err_cnt), 32'd1);
      end

      // Asynchronous reset between edges, right after a compare result appears.
      issue(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h33, 8'h31, 8'hFF);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;

`ifdef BIST_CMP_MASK_EN
      cmp_mask = 8'hF0;
      issue(8'hA5, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      cmp_mask = 8'hFF;
      issue(8'hA5, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'hA5, 8'hA3, 8'h06);
`endif

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
